plab5_mcore_mem_resp_port: RTL and testbench
============================================

Name: plab5_mcore_mem_resp_port

Overview:
- Memory-side responder for the split control/data memory interface driven by the memory address space controller.
- Accepts domain-tagged memory requests, performs word reads/writes on an internal storage array, and returns domain-tagged responses through a 2-entry response queue.
- Sits at the memory end of each controller's mem_req/mem_resp port pair.
- Allows request acceptance back-to-back with response drain at full throughput.

Parameters:
- mem_size, 1<<16, storage size in bytes (word array of mem_size/4 entries).
- p_opaque_nbits, 8, opaque field width.
- p_addr_nbits, 32, address field width.
- p_data_nbits, 32, data field width.
- req_cnbits, 45, request control width = type(3)+opaque(8)+addr(32)+len(2); fixed, derived.
- resp_cnbits, 13, response control width = type(3)+opaque(8)+len(2); fixed, derived.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- mem_req_control  in  req_cnbits  request control {type[44:42], opaque[41:34], addr[33:2], len[1:0]}.
- mem_req_data  in  p_data_nbits  write data.
- mem_req_val  in  1  request valid.
- mem_req_rdy  out  1  request ready.
- mem_req_domain  in  1  security domain of the current request (0 = low, 1 = high).
- mem_resp_control  out  resp_cnbits  response control {type[12:10], opaque[9:2], len[1:0]}.
- mem_resp_data  out  p_data_nbits  read data.
- mem_resp_val  out  1  response valid.
- mem_resp_rdy  in  1  response ready.
- mem_resp_domain  out  1  domain of the head response.

Behaviour:
- Reset:
  - Queue count = 0, head/tail pointers = 0.
  - mem_resp_val = 0, mem_resp_domain = 0, mem_req_rdy = 1 in the cycle after reset deasserts.
  - Storage array is not cleared.
  - Reset mid-operation drops all queued responses; in-flight writes already committed stay in the array.
- Types: 3'd0 = read, 3'd1 = write. Any other type is treated as a read with data forced to 0 and no array access. len is ignored: every access is a full word, and addr[1:0] is ignored.
- Word index = addr[p_addr_nbits-1:2]. If addr >= mem_size, the access is out of range: write is dropped, read returns 0, and a response is still generated.
- Handshake:
  - Request fires on mem_req_val && mem_req_rdy.
  - Response fires on mem_resp_val && mem_resp_rdy.
  - mem_req_rdy = (count < 2) || (count == 2 && resp fire).
  - mem_req_rdy must not depend combinationally on mem_req_val.
- On request fire at edge N:
  - Write: array[idx] <= data.
  - Read: array[idx] is sampled combinationally before the edge.
  - Enqueue entry {type, opaque, len, data, mem_req_domain}; write responses carry data = 0.
- Latency: a response is visible at the earliest in cycle N+1. Throughput is 1 request/cycle with mem_resp_rdy held high.
- Ordering: responses return strictly in request order. A read accepted the cycle after a write to the same word returns the new data.
- Queue:
  - Count 0: mem_resp_val = 0, mem_resp_domain holds its last value.
  - Count 2 with no dequeue: mem_req_rdy = 0.
  - Simultaneous enqueue and dequeue leaves count unchanged; pointers wrap modulo 2.
- Domain: mem_resp_domain = domain of the head entry whenever count > 0. It is updated in the same cycle the head changes, so control, data, val and domain are always consistent.
- Outputs are held stable while mem_resp_val = 1 and mem_resp_rdy = 0.
- State machine for the queue count: EMPTY (0) -> ONE on enqueue; ONE -> TWO on enqueue without dequeue; ONE -> EMPTY on dequeue without enqueue; TWO -> ONE on dequeue without enqueue. All other combinations hold the current state.

Test Plan:
- Write addr 0x0100 data 0xdeadbeef opaque 0x05 domain 1, then read 0x0100 opaque 0x06 domain 1 -> resp1 {type 1, opaque 0x05, data 0}, resp2 {type 0, opaque 0x06, data 0xdeadbeef}, both with mem_resp_domain = 1; resp1 valid exactly 1 cycle after accept.
- Three back-to-back requests with mem_resp_rdy = 0 -> first two accepted, mem_req_rdy = 0 on the third. Raise mem_resp_rdy -> third accepted in the same cycle as the first dequeue; all three responses arrive in order.
- Read addr 0x10000 (with mem_size = 0x10000) -> data 0, response generated. Write 0x10004 data 0x1234 -> dropped; a later in-range read of 0x0004 is unaffected.
- Alternating domains 0/1/0 with reads -> mem_resp_domain tracks each head entry: 0, 1, 0, aligned with mem_resp_val.
- Assert reset with 2 queued responses -> next cycle mem_resp_val = 0, mem_req_rdy = 1. A read of a previously written word still returns the written value.
- Type 3'd2 request, opaque 0x7f -> response {type 2, opaque 0x7f, data 0}, array unchanged.

Source files
------------

// File: rtl/plab5_mcore_mem_resp_port.sv
`default_nettype none
//============================================================================
// Module   : plab5_mcore_mem_resp_port
// Purpose  : Memory-side responder for the split control/data memory port.
//            Accepts domain-tagged word read/write requests, accesses an
//            internal word array and returns domain-tagged responses, in
//            request order, through a 2-entry response queue.
// Ports    : clk, reset                 - clock, synchronous active-high reset
//            mem_req_control/data/val   - request {type,opaque,addr,len}, data
//            mem_req_rdy                - request ready
//            mem_req_domain             - security domain of the request
//            mem_resp_control/data/val  - response {type,opaque,len}, data
//            mem_resp_rdy               - response ready
//            mem_resp_domain            - domain of the head response
// Revision : 1.0 - initial release
//============================================================================
module plab5_mcore_mem_resp_port #(
   parameter int mem_size       = 1 << 16,
   parameter int p_opaque_nbits = 8,
   parameter int p_addr_nbits   = 32,
   parameter int p_data_nbits   = 32,
   parameter int req_cnbits     = 3 + p_opaque_nbits + p_addr_nbits + 2,
   parameter int resp_cnbits    = 3 + p_opaque_nbits + 2
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [req_cnbits-1:0]   mem_req_control,
   input  logic [p_data_nbits-1:0] mem_req_data,
   input  logic                    mem_req_val,
   output logic                    mem_req_rdy,
   input  logic                    mem_req_domain,
   output logic [resp_cnbits-1:0]  mem_resp_control,
   output logic [p_data_nbits-1:0] mem_resp_data,
   output logic                    mem_resp_val,
   input  logic                    mem_resp_rdy,
   output logic                    mem_resp_domain
);

   localparam int num_words = mem_size / 4;
   localparam int idx_nbits = $clog2(num_words);

   localparam logic [2:0] type_read  = 3'd0;
   localparam logic [2:0] type_write = 3'd1;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } state_t;

   // ------------------------------------------------------------------
   // Request field decode
   // ------------------------------------------------------------------
   logic [2:0]                req_type;
   logic [p_opaque_nbits-1:0] req_opaque;
   logic [p_addr_nbits-1:0]   req_addr;
   logic [1:0]                req_len;
   logic [idx_nbits-1:0]      req_idx;
   logic                      req_in_range;

   assign req_type     = mem_req_control[req_cnbits-1 -: 3];
   assign req_opaque   = mem_req_control[req_cnbits-4 -: p_opaque_nbits];
   assign req_addr     = mem_req_control[p_addr_nbits+1 : 2];
   assign req_len      = mem_req_control[1:0];
   // addr[1:0] is dropped: every access is a full aligned word.
   assign req_idx      = req_addr[idx_nbits+1 : 2];
   assign req_in_range = (req_addr < p_addr_nbits'(mem_size));

   // ------------------------------------------------------------------
   // Storage array (never cleared by reset)
   // ------------------------------------------------------------------
   logic [p_data_nbits-1:0] storage [0:num_words-1];
   logic [p_data_nbits-1:0] rd_word;
   logic [p_data_nbits-1:0] enq_data;

   assign rd_word = storage[req_idx];

   // Only in-range reads return array data; writes, out-of-range reads
   // and unknown types all respond with zero.
   assign enq_data = ((req_type == type_read) && req_in_range) ? rd_word
                                                               : '0;

   // ------------------------------------------------------------------
   // Handshake
   // ------------------------------------------------------------------
   logic req_fire;
   logic resp_fire;

   assign req_fire  = mem_req_val && mem_req_rdy;
   assign resp_fire = mem_resp_val && mem_resp_rdy;

   always_ff @(posedge clk) begin
      if (req_fire && (req_type == type_write) && req_in_range)
         storage[req_idx] <= mem_req_data;
   end

   // ------------------------------------------------------------------
   // Response queue: 2 entries, 1-bit head/tail pointers
   // ------------------------------------------------------------------
   logic [2:0]                q_type   [0:1];
   logic [p_opaque_nbits-1:0] q_opaque [0:1];
   logic [1:0]                q_len    [0:1];
   logic [p_data_nbits-1:0]   q_data   [0:1];
   logic                      q_domain [0:1];
   logic                      head;
   logic                      tail;
   logic                      last_domain;

   state_t state;
   state_t state_next;

   always_ff @(posedge clk) begin
      if (req_fire) begin
         q_type[tail]   <= req_type;
         q_opaque[tail] <= req_opaque;
         q_len[tail]    <= req_len;
         q_data[tail]   <= enq_data;
         q_domain[tail] <= mem_req_domain;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         head        <= 1'b0;
         tail        <= 1'b0;
         last_domain <= 1'b0;
      end else begin
         if (req_fire)
            tail <= ~tail;
         if (resp_fire) begin
            head        <= ~head;
            last_domain <= q_domain[head];
         end
      end
   end

   // ------------------------------------------------------------------
   // Occupancy state machine
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset)
         state <= EMPTY;
      else
         state <= state_next;
   end

   always_comb begin
      state_next  = state;
      mem_resp_val = (state != EMPTY);
      // In TWO the head is always valid, so a ready response means a
      // dequeue this cycle and the freed slot can be refilled at once.
      mem_req_rdy  = (state != TWO) || mem_resp_rdy;

      case (state)
         EMPTY: if (req_fire)               state_next = ONE;
         ONE:   if (req_fire && !resp_fire) state_next = TWO;
                else if (!req_fire && resp_fire) state_next = EMPTY;
         TWO:   if (!req_fire && resp_fire) state_next = ONE;
         default:                           state_next = EMPTY;
      endcase
   end

   assign mem_resp_control = {q_type[head], q_opaque[head], q_len[head]};
   assign mem_resp_data    = q_data[head];
   // Domain follows the head entry; when empty it keeps the domain of the
   // most recently drained response.
   assign mem_resp_domain  = mem_resp_val ? q_domain[head] : last_domain;

endmodule
`default_nettype wire

// File: tb/tb_plab5_mcore_mem_resp_port.sv
`default_nettype none
//============================================================================
// Module   : tb_plab5_mcore_mem_resp_port
// Purpose  : Self-checking bench for plab5_mcore_mem_resp_port. A table of
//            single-request vectors is applied in a loop, followed by
//            hand-written back-to-back, backpressure, domain and reset
//            sequences.
// Revision : 1.0 - initial release
//============================================================================
module tb_plab5_mcore_mem_resp_port;

   logic        clk;
   logic        reset;
   logic [44:0] mem_req_control;
   logic [31:0] mem_req_data;
   logic        mem_req_val;
   logic        mem_req_rdy;
   logic        mem_req_domain;
   logic [12:0] mem_resp_control;
   logic [31:0] mem_resp_data;
   logic        mem_resp_val;
   logic        mem_resp_rdy;
   logic        mem_resp_domain;

   plab5_mcore_mem_resp_port dut (
      .clk              (clk),
      .reset            (reset),
      .mem_req_control  (mem_req_control),
      .mem_req_data     (mem_req_data),
      .mem_req_val      (mem_req_val),
      .mem_req_rdy      (mem_req_rdy),
      .mem_req_domain   (mem_req_domain),
      .mem_resp_control (mem_resp_control),
      .mem_resp_data    (mem_resp_data),
      .mem_resp_val     (mem_resp_val),
      .mem_resp_rdy     (mem_resp_rdy),
      .mem_resp_domain  (mem_resp_domain)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic [2:0]  typ;
      logic [7:0]  op;
      logic [31:0] addr;
      logic [31:0] data;
      logic [1:0]  len;
      logic        dom;
      logic [2:0]  e_typ;
      logic [31:0] e_data;
   } vec_t;

   vec_t vecs [10];

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Compares {val, type, opaque, len, data, domain} of the head response.
   task automatic chk_resp(input string name, input logic [2:0] e_typ,
                           input logic [7:0] e_op, input logic [1:0] e_len,
                           input logic [31:0] e_data, input logic e_dom);
      chk(name,
          {17'd0, mem_resp_val, mem_resp_control, mem_resp_data, mem_resp_domain},
          {17'd0, 1'b1, e_typ, e_op, e_len, e_data, e_dom});
   endtask

   task automatic drive_req(input logic [2:0] typ, input logic [7:0] op,
                            input logic [31:0] addr, input logic [31:0] data,
                            input logic [1:0] len, input logic dom);
      mem_req_control = {typ, op, addr, len};
      mem_req_data    = data;
      mem_req_domain  = dom;
      mem_req_val     = 1'b1;
   endtask

   task automatic idle_req();
      mem_req_val     = 1'b0;
      mem_req_control = '0;
      mem_req_data    = '0;
      mem_req_domain  = 1'b0;
   endtask

   logic prev_dom;

   initial begin
      // typ, op, addr, data, len, dom, exp type, exp data
      vecs[0] = '{3'd1, 8'h05, 32'h0000_0100, 32'hdead_beef, 2'd0, 1'b1, 3'd1, 32'h0};
      vecs[1] = '{3'd0, 8'h06, 32'h0000_0100, 32'h0,         2'd0, 1'b1, 3'd0, 32'hdead_beef};
      vecs[2] = '{3'd0, 8'h10, 32'h0001_0000, 32'h0,         2'd0, 1'b0, 3'd0, 32'h0};
      vecs[3] = '{3'd1, 8'h11, 32'h0000_0004, 32'hcafe_f00d, 2'd0, 1'b0, 3'd1, 32'h0};
      vecs[4] = '{3'd1, 8'h12, 32'h0001_0004, 32'h0000_1234, 2'd0, 1'b1, 3'd1, 32'h0};
      vecs[5] = '{3'd0, 8'h13, 32'h0000_0004, 32'h0,         2'd0, 1'b0, 3'd0, 32'hcafe_f00d};
      vecs[6] = '{3'd2, 8'h7f, 32'h0000_0100, 32'h0000_0055, 2'd0, 1'b1, 3'd2, 32'h0};
      vecs[7] = '{3'd0, 8'h14, 32'h0000_0100, 32'h0,         2'd0, 1'b0, 3'd0, 32'hdead_beef};
      vecs[8] = '{3'd0, 8'h15, 32'h0000_0102, 32'h0,         2'd2, 1'b1, 3'd0, 32'hdead_beef};
      vecs[9] = '{3'd0, 8'h16, 32'hffff_fffc, 32'h0,         2'd1, 1'b0, 3'd0, 32'h0};

      reset        = 1'b1;
      mem_resp_rdy = 1'b1;
      idle_req();
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("reset_state", {61'd0, mem_resp_val, mem_req_rdy, mem_resp_domain},
          {61'd0, 1'b0, 1'b1, 1'b0});

      // ---------------- table-driven single requests ----------------
      prev_dom = 1'b0;
      for (int i = 0; i < 10; i++) begin
         chk($sformatf("v%0d_empty", i), {62'd0, mem_resp_val, mem_resp_domain},
             {62'd0, 1'b0, prev_dom});
         drive_req(vecs[i].typ, vecs[i].op, vecs[i].addr, vecs[i].data,
                   vecs[i].len, vecs[i].dom);
         #1;
         chk($sformatf("v%0d_req_rdy", i), {63'd0, mem_req_rdy}, 64'd1);
         @(negedge clk);
         idle_req();
         chk_resp($sformatf("v%0d_resp", i), vecs[i].e_typ, vecs[i].op,
                  vecs[i].len, vecs[i].e_data, vecs[i].dom);
         prev_dom = vecs[i].dom;
         @(negedge clk);
      end

      // ---------------- write then read same word back-to-back ----------------
      drive_req(3'd1, 8'h20, 32'h0000_0200, 32'h0bad_f00d, 2'd0, 1'b0);
      @(negedge clk);
      chk_resp("wr_rd_resp1", 3'd1, 8'h20, 2'd0, 32'h0, 1'b0);
      drive_req(3'd0, 8'h21, 32'h0000_0200, 32'h0, 2'd0, 1'b0);
      @(negedge clk);
      idle_req();
      chk_resp("wr_rd_resp2", 3'd0, 8'h21, 2'd0, 32'h0bad_f00d, 1'b0);
      @(negedge clk);
      chk("wr_rd_empty", {63'd0, mem_resp_val}, 64'd0);

      // ---------------- backpressure: three requests, resp_rdy low ----------------
      mem_resp_rdy = 1'b0;
      drive_req(3'd0, 8'h30, 32'h0000_0100, 32'h0, 2'd0, 1'b0);
      #1;
      chk("bp_rdy_a", {63'd0, mem_req_rdy}, 64'd1);
      @(negedge clk);
      chk_resp("bp_head_a1", 3'd0, 8'h30, 2'd0, 32'hdead_beef, 1'b0);
      drive_req(3'd0, 8'h31, 32'h0000_0004, 32'h0, 2'd0, 1'b1);
      #1;
      chk("bp_rdy_b", {63'd0, mem_req_rdy}, 64'd1);
      @(negedge clk);
      drive_req(3'd0, 8'h32, 32'h0000_0200, 32'h0, 2'd0, 1'b1);
      #1;
      chk("bp_rdy_c_full", {63'd0, mem_req_rdy}, 64'd0);
      @(negedge clk);
      chk("bp_rdy_c_still_full", {63'd0, mem_req_rdy}, 64'd0);
      chk_resp("bp_head_a_stable", 3'd0, 8'h30, 2'd0, 32'hdead_beef, 1'b0);
      mem_resp_rdy = 1'b1;
      #1;
      chk("bp_rdy_c_on_deq", {63'd0, mem_req_rdy}, 64'd1);
      @(negedge clk);
      idle_req();
      chk_resp("bp_head_b", 3'd0, 8'h31, 2'd0, 32'hcafe_f00d, 1'b1);
      @(negedge clk);
      chk_resp("bp_head_c", 3'd0, 8'h32, 2'd0, 32'h0bad_f00d, 1'b1);
      @(negedge clk);
      chk("bp_empty_dom_hold", {62'd0, mem_resp_val, mem_resp_domain},
          {62'd0, 1'b0, 1'b1});

      // ---------------- alternating domains 0/1/0 ----------------
      drive_req(3'd0, 8'h40, 32'h0000_0100, 32'h0, 2'd0, 1'b0);
      @(negedge clk);
      chk_resp("dom_r0", 3'd0, 8'h40, 2'd0, 32'hdead_beef, 1'b0);
      drive_req(3'd0, 8'h41, 32'h0000_0004, 32'h0, 2'd0, 1'b1);
      @(negedge clk);
      chk_resp("dom_r1", 3'd0, 8'h41, 2'd0, 32'hcafe_f00d, 1'b1);
      drive_req(3'd0, 8'h42, 32'h0000_0200, 32'h0, 2'd0, 1'b0);
      @(negedge clk);
      idle_req();
      chk_resp("dom_r2", 3'd0, 8'h42, 2'd0, 32'h0bad_f00d, 1'b0);
      @(negedge clk);
      chk("dom_empty", {62'd0, mem_resp_val, mem_resp_domain}, {62'd0, 1'b0, 1'b0});

      // ---------------- reset with two queued responses ----------------
      mem_resp_rdy = 1'b0;
      drive_req(3'd0, 8'h50, 32'h0000_0100, 32'h0, 2'd0, 1'b1);
      @(negedge clk);
      drive_req(3'd0, 8'h51, 32'h0000_0004, 32'h0, 2'd0, 1'b1);
      @(negedge clk);
      idle_req();
      chk("rst_full", {62'd0, mem_resp_val, mem_req_rdy}, {62'd0, 1'b1, 1'b0});
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("rst_dropped", {61'd0, mem_resp_val, mem_req_rdy, mem_resp_domain},
          {61'd0, 1'b0, 1'b1, 1'b0});
      mem_resp_rdy = 1'b1;
      drive_req(3'd0, 8'h52, 32'h0000_0100, 32'h0, 2'd0, 1'b0);
      @(negedge clk);
      idle_req();
      chk_resp("rst_read_kept", 3'd0, 8'h52, 2'd0, 32'hdead_beef, 1'b0);
      @(negedge clk);
      chk("rst_final_empty", {63'd0, mem_resp_val}, 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
